// File: rtl/cga_pkg.sv
// Shared types and default constants for the CGA video RAM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_LATCH  = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_t;

    // Parked CPU cycle: direction, 16K-window offset and write data.
    typedef struct packed {
        logic        is_wr;
        logic [13:0] addr;
        logic [7:0]  dat;
    } cpu_req_t;

    localparam logic [19:0] FB_BASE_DEF    = 20'hB8000;
    localparam logic [19:0] FB_DECODE_MASK = 20'hF8000;
    localparam logic [4:0]  RAM_BANK_DEF   = 5'b00010;
    localparam logic [4:0]  SLOT_START_DEF = 5'd17;
    localparam logic [4:0]  SLOT_END_DEF   = 5'd20;

    function automatic logic fb_hit(input logic [19:0] a, input logic [19:0] base);
        return (a & FB_DECODE_MASK) == (base & FB_DECODE_MASK);
    endfunction

    function automatic logic in_slot(input logic [4:0] seq, input logic [4:0] lo,
                                     input logic [4:0] hi);
        return (seq >= lo) && (seq <= hi);
    endfunction

endpackage

// File: rtl/cga_bus_sync.sv
// Two-flop synchronizer for the ISA memory strobes with edge pulses.
// Latency: synced level and edge pulses appear 2 clk after the strobe moves.
// Backpressure: none; pure sampling of free-running async strobes.
module cga_bus_sync (
    input  logic clk,
    input  logic reset_l,
    input  logic memr_l,
    input  logic memw_l,
    output logic memr_s,
    output logic memw_s,
    output logic memr_fall,
    output logic memw_fall,
    output logic memr_rise,
    output logic memw_rise
);

    logic [1:0] r_sync;
    logic [1:0] w_sync;
    logic       r_q;
    logic       w_q;

    // Strobes are active-low, so everything resets to the released level.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_sync <= 2'b11;
            w_sync <= 2'b11;
            r_q    <= 1'b1;
            w_q    <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], memr_l};
            w_sync <= {w_sync[0], memw_l};
            r_q    <= r_sync[1];
            w_q    <= w_sync[1];
        end
    end

    assign memr_s    = r_sync[1];
    assign memw_s    = w_sync[1];
    assign memr_fall = r_q & ~r_sync[1];
    assign memw_fall = w_q & ~w_sync[1];
    assign memr_rise = ~r_q & r_sync[1];
    assign memw_rise = ~w_q & w_sync[1];

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the single-port CGA VRAM between display fetches and ISA CPU cycles.
// Latency: best case sync 2 clk + ACCESS + LATCH; worst case one sequencer period + 3 clk.
// Backpressure: bus_rdy held low while a CPU cycle is parked; display always wins the RAM.
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter logic [19:0] FB_BASE      = FB_BASE_DEF,
    parameter logic [4:0]  RAM_BANK     = RAM_BANK_DEF,
    parameter logic [4:0]  SLOT_START   = SLOT_START_DEF,
    parameter logic [4:0]  SLOT_END     = SLOT_END_DEF,
    parameter bit          USE_BUS_WAIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [19:0] bus_a,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic        bus_aen,
    input  logic [7:0]  bus_d,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    output logic        bus_rdy,
    input  logic [4:0]  clk_seq,
    input  logic        vram_read,
    input  logic [18:0] disp_addr,
    output logic [18:0] ram_a,
    output logic        ram_we_l,
    output logic [7:0]  ram_wd,
    input  logic [7:0]  ram_d
);

    logic memr_s, memw_s, memr_fall, memw_fall, memr_rise, memw_rise;

    cga_bus_sync u_sync (
        .clk       (clk),
        .reset_l   (reset_l),
        .memr_l    (bus_memr_l),
        .memw_l    (bus_memw_l),
        .memr_s    (memr_s),
        .memw_s    (memw_s),
        .memr_fall (memr_fall),
        .memw_fall (memw_fall),
        .memr_rise (memr_rise),
        .memw_rise (memw_rise)
    );

    arb_state_t  state_q, state_d;
    cpu_req_t    req_q;
    logic [7:0]  rd_latch;
    logic        req_hit, rd_req, wr_req;
    logic [4:0]  seq_next;
    logic        slot_ok;
    logic        rdy_fsm, cpu_sel, we_l, dir;

    // A strobe that falls while the other is still low is ignored.
    assign req_hit  = fb_hit(bus_a, FB_BASE) & ~bus_aen;
    assign rd_req   = memr_fall & memw_s & req_hit;
    assign wr_req   = memw_fall & memr_s & req_hit;

    // The grant decision is registered, so look one phase ahead to land ACCESS in the slot.
    assign seq_next = clk_seq + 5'd1;
    assign slot_ok  = in_slot(seq_next, SLOT_START, SLOT_END);

    always_comb begin
        state_d = state_q;
        rdy_fsm = 1'b1;
        cpu_sel = 1'b0;
        we_l    = 1'b1;
        dir     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_req || wr_req) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                rdy_fsm = 1'b0;
                // A display retry out of ACCESS can swallow the rise edge, so the level counts too.
                if (!req_q.is_wr && (memr_rise || memr_s)) state_d = ST_IDLE;
                else if (slot_ok && !vram_read)            state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                rdy_fsm = 1'b0;
                if (vram_read) begin
                    state_d = ST_WAIT;
                end else begin
                    cpu_sel = 1'b1;
                    we_l    = ~req_q.is_wr;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                rdy_fsm = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                dir = ~req_q.is_wr & ~memr_s;
                if (req_q.is_wr ? (memw_s || memw_rise) : (memr_s || memr_rise))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            rd_latch <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && (rd_req || wr_req))
                req_q <= '{is_wr: wr_req, addr: bus_a[13:0], dat: bus_d};
            if (state_q == ST_LATCH && !req_q.is_wr)
                rd_latch <= ram_d;
        end
    end

    assign ram_a    = cpu_sel ? {RAM_BANK, req_q.addr} : disp_addr;
    assign ram_we_l = we_l;
    assign ram_wd   = req_q.dat;
    assign bus_dir  = dir;
    assign bus_out  = dir ? rd_latch : 8'h00;
    assign bus_rdy  = USE_BUS_WAIT ? rdy_fsm : 1'b1;

endmodule
